// File: rtl/rand_matrix_gen_if.sv
// rand_matrix_gen_if: job request, element stream and status of the random
// matrix generator.
//   master : generator side (drives elem_*, busy, done, err)
//   slave  : requester/consumer side (drives start, dims, bounds, elem_ready)
interface rand_matrix_gen_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       rows;
  logic [3:0]       cols;
  logic [WIDTH-1:0] min_val;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] elem_data;
  logic [3:0]       elem_row;
  logic [3:0]       elem_col;
  logic             elem_valid;
  logic             elem_ready;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  start, rows, cols, min_val, max_val, elem_ready,
    output elem_data, elem_row, elem_col, elem_valid, busy, done, err
  );

  modport slave (
    output start, rows, cols, min_val, max_val, elem_ready,
    input  elem_data, elem_row, elem_col, elem_valid, busy, done, err
  );
endinterface

// File: rtl/rand_matrix_gen.sv
// rand_matrix_gen: on a start pulse fills a rows x cols matrix with
// pseudo-random elements bounded to [min_val, max_val] and streams them
// row-major over elem_valid/elem_ready.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : rand_matrix_gen_if.master (request, element stream, status)
//   seed_load, seed : only when RMG_SEED_LOAD_EN is defined; reloads the LFSR
// Optional feature macro: RMG_SEED_LOAD_EN
module rand_matrix_gen #(
  parameter int          WIDTH   = 8,
  parameter int          MAX_DIM = 5,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
`ifdef RMG_SEED_LOAD_EN
  input  logic        seed_load,
  input  logic [15:0] seed,
`endif
  rand_matrix_gen_if.master bus
);

  typedef enum logic [2:0] {IDLE, CHECK, EMIT, HOLD, DONE} state_t;

  // An all-zero LFSR would lock up, so zero seeds fall back to the default.
  localparam logic [15:0] SEED_INIT = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [15:0] MASK      = 16'hB400;
  localparam logic [3:0]  MD        = 4'(MAX_DIM);

  state_t           state, state_nx;
  logic [15:0]      lfsr, lfsr_nx;
  logic [3:0]       rows_q, cols_q;
  logic [WIDTH-1:0] min_q, max_q, elem;
  logic [WIDTH:0]   span;
  logic [2*WIDTH-1:0] prod;
  logic             bad_job, hs, last;

  // Galois step; free-runs in every state.
  always_comb begin
    lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? MASK : 16'h0);
`ifdef RMG_SEED_LOAD_EN
    if (seed_load) lfsr_nx = (seed == 16'h0) ? 16'hACE1 : seed;
`endif
  end

  // Scale the low LFSR bits into [0, span): (r * span) >> WIDTH < span.
  // span is one bit wider so the full range min=0,max=all-ones gives 2^WIDTH.
  assign span = {1'b0, max_q} - {1'b0, min_q} + (WIDTH+1)'(1);
  assign prod = (2*WIDTH)'(lfsr[WIDTH-1:0]) * (2*WIDTH)'(span);
  assign elem = min_q + WIDTH'(prod >> WIDTH);

  assign bad_job = (rows_q == 4'd0) || (cols_q == 4'd0) ||
                   (rows_q > MD) || (cols_q > MD) || (min_q > max_q);
  assign hs   = bus.elem_valid && bus.elem_ready;
  assign last = (bus.elem_row == rows_q - 4'd1) && (bus.elem_col == cols_q - 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.start) state_nx = CHECK;
      CHECK: state_nx = bad_job ? DONE : EMIT;
      EMIT:  state_nx = HOLD;
      HOLD:  if (hs && last) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr           <= SEED_INIT;
      rows_q         <= '0;
      cols_q         <= '0;
      min_q          <= '0;
      max_q          <= '0;
      bus.elem_data  <= '0;
      bus.elem_row   <= '0;
      bus.elem_col   <= '0;
      bus.elem_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      lfsr     <= lfsr_nx;
      // DONE lasts exactly one cycle, so done mirrors entry into it.
      bus.done <= (state_nx == DONE);
      unique case (state)
        IDLE: if (bus.start) begin
          rows_q   <= bus.rows;
          cols_q   <= bus.cols;
          min_q    <= bus.min_val;
          max_q    <= bus.max_val;
          bus.busy <= 1'b1;
          bus.err  <= 1'b0;
        end
        CHECK: begin
          if (bad_job) bus.err <= 1'b1;
          else begin
            bus.elem_row <= '0;
            bus.elem_col <= '0;
          end
        end
        EMIT: begin
          bus.elem_data  <= elem;
          bus.elem_valid <= 1'b1;
        end
        HOLD: if (hs) begin
          if (last) bus.elem_valid <= 1'b0;
          else begin
            bus.elem_data <= elem;
            if (bus.elem_col == cols_q - 4'd1) begin
              bus.elem_col <= '0;
              bus.elem_row <= bus.elem_row + 4'd1;
            end else begin
              bus.elem_col <= bus.elem_col + 4'd1;
            end
          end
        end
        DONE: bus.busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_matrix_gen.sv
module tb_rand_matrix_gen;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rand_matrix_gen_if #(.WIDTH(W)) bus();

`ifdef RMG_SEED_LOAD_EN
  logic        seed_load = 1'b0;
  logic [15:0] seed      = 16'h0;
`endif

  rand_matrix_gen #(.WIDTH(W), .MAX_DIM(5), .SEED(16'hACE1)) dut (
    .clk(clk),
    .rst(rst),
`ifdef RMG_SEED_LOAD_EN
    .seed_load(seed_load),
    .seed(seed),
`endif
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // job description shared with the monitor
  int job_rows, job_cols, job_min, job_max;
  int idx, elem_cnt;
  int got_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lfsr_step(input int x);
    return (x % 2 == 1) ? ((x / 2) ^ 'hB400) : (x / 2);
  endfunction

  function automatic int map_val(input int l, input int mn, input int mx);
    int span;
    span = mx - mn + 1;
    return mn + ((l % 256) * span) / 256;
  endfunction

  // Reference LFSR: m is the current value, m_prev the value in effect
  // before the most recent edge (the one an element loaded at that edge used).
  int m, m_prev;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m      <= 'hACE1;
      m_prev <= 'hACE1;
    end else begin
      m_prev <= m;
      m      <= lfsr_step(m);
`ifdef RMG_SEED_LOAD_EN
      if (seed_load) m <= (seed == 16'h0) ? 'hACE1 : int'(seed);
`endif
    end
  end

  // Stream monitor: new elements are checked against the model, held ones for stability.
  bit prev_valid = 0, hs_prev = 0;
  logic [15:0] held_idx;
  logic [7:0]  held_data;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
      hs_prev    = 0;
    end else begin
      if (bus.elem_valid) begin
        if (!prev_valid || hs_prev) begin
          int c;
          c = (job_cols == 0) ? 1 : job_cols;
          chk("elem_data", bus.elem_data, map_val(m_prev, job_min, job_max));
          chk("elem_idx", {bus.elem_row, bus.elem_col}, {4'(idx / c), 4'(idx % c)});
          chk("elem_range", (int'(bus.elem_data) >= job_min) && (int'(bus.elem_data) <= job_max), 1);
          got_q.push_back(int'(bus.elem_data));
          elem_cnt++;
          held_data = bus.elem_data;
          held_idx  = {8'h0, bus.elem_row, bus.elem_col};
        end else begin
          chk("hold_stable", {bus.elem_data, bus.elem_row, bus.elem_col},
              {held_data, held_idx[7:0]});
        end
      end
      hs_prev    = bus.elem_valid && bus.elem_ready;
      if (hs_prev) idx++;
      prev_valid = bus.elem_valid;
    end
  end

  // exp_lat = 0 skips the latency check (random backpressure)
  task automatic run_job(input int r, input int c, input int mn, input int mx,
                         input bit rand_ready, input bit exp_err, input int exp_lat,
                         input bit restart);
    int n;
    @(posedge clk); #2;
    job_rows = r; job_cols = c; job_min = mn; job_max = mx;
    idx = 0; elem_cnt = 0; got_q.delete();
    bus.rows = 4'(r); bus.cols = 4'(c);
    bus.min_val = 8'(mn); bus.max_val = 8'(mx);
    bus.start = 1'b1;
    bus.elem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    n = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) break;
      #1;
      bus.start = restart && (n == 5);
      if (n == 2) begin
        bus.rows = 4'd1; bus.cols = 4'd1; bus.min_val = 8'd0; bus.max_val = 8'd0;
      end
      bus.elem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk("done_seen", n < 300, 1);
    if (exp_lat > 0) chk("latency", n, exp_lat);
    chk("err", bus.err, exp_err);
    chk("busy_at_done", bus.busy, 1);
    chk("elem_count", elem_cnt, exp_err ? 0 : r * c);
    bus.start = 1'b0;
    bus.elem_ready = 1'b1;
    @(posedge clk); #1;
    chk("after_done", {bus.busy, bus.done, bus.err, bus.elem_valid}, {3'b000 | 3'(exp_err), 1'b0});
  endtask

`ifdef RMG_SEED_LOAD_EN
  task automatic seeded_job(input logic [15:0] s);
    @(posedge clk); #2;
    seed = s; seed_load = 1'b1;
    @(posedge clk); #2;
    seed_load = 1'b0;
    run_job(2, 2, 0, 255, 0, 0, 7, 0);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0; bus.rows = '0; bus.cols = '0;
    bus.min_val = '0; bus.max_val = '0; bus.elem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", {bus.elem_valid, bus.busy, bus.done, bus.err,
                        bus.elem_row, bus.elem_col, bus.elem_data}, 32'h0);
    @(posedge clk); #2 rst = 1'b0;

    run_job(2, 3, 0, 15, 0, 0, 9, 0);       // basic, done 9 cycles after start
    run_job(5, 5, 7, 7, 0, 0, 28, 0);       // min==max, max dims
    run_job(3, 3, 10, 200, 1, 0, 0, 0);     // random backpressure
    run_job(3, 3, 0, 255, 1, 0, 0, 0);      // full range, backpressure
    run_job(1, 1, 255, 255, 0, 0, 4, 0);    // single element at the top value
    run_job(0, 3, 0, 15, 0, 1, 2, 0);       // rows=0
    run_job(2, 6, 0, 15, 0, 1, 2, 0);       // cols > MAX_DIM
    run_job(2, 2, 20, 10, 0, 1, 2, 0);      // min > max
    run_job(4, 4, 0, 99, 0, 0, 19, 1);      // restart pulse mid-job ignored

    for (int k = 0; k < 4; k++) begin
      int a, b, lo, hi;
      a  = $urandom_range(1, 5);
      b  = $urandom_range(1, 5);
      lo = $urandom_range(0, 255);
      hi = $urandom_range(lo, 255);
      run_job(a, b, lo, hi, 1, 0, 0, 0);
    end

    // reset mid-job
    @(posedge clk); #2;
    job_rows = 3; job_cols = 3; job_min = 0; job_max = 255;
    idx = 0; elem_cnt = 0;
    bus.rows = 4'd3; bus.cols = 4'd3; bus.min_val = 8'd0; bus.max_val = 8'd255;
    bus.start = 1'b1;
    @(posedge clk); #2 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_job", {bus.elem_valid, bus.busy, bus.done, bus.err,
                        bus.elem_row, bus.elem_col, bus.elem_data}, 32'h0);
    @(posedge clk); #2 rst = 1'b0;
    run_job(2, 2, 0, 255, 0, 0, 7, 0);      // data follows a freshly reset LFSR

`ifdef RMG_SEED_LOAD_EN
    begin
      int first_q[$];
      seeded_job(16'h1234);
      first_q = got_q;
      seeded_job(16'h1234);
      for (int k = 0; k < 4; k++) chk("seed_repeat", got_q[k], first_q[k]);
      seeded_job(16'h0000);
      first_q = got_q;
      seeded_job(16'hACE1);
      for (int k = 0; k < 4; k++) chk("seed_zero", got_q[k], first_q[k]);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
